dataio_spi_master: RTL and testbench

SPI-master source for the MiST data_io download protocol. Drives `SPI_SCK`/`SPI_SS2`/`SPI_DI` into the core's `mist_io` so that a file (ROM, CAS) arrives as an `ioctl_download` stream. It is used for on-FPGA boot loaders and as the stimulus driver in core testbenches. Upstream is a byte stream with valid/ready; downstream is the SS2 file-transfer channel.

---
 rtl/dataio_spi_master.sv | 223 ++++++++++++++++++++++
 tb/tb_dataio_spi_master.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataio_spi_master.sv
// SPI master that feeds a file into mist_io's data_io channel on SPI_SS2:
// index frame, download-start frame, payload frame, download-end frame.
// Optional payload XOR checksum output `cksum`, enabled by defining DATAIO_CKSUM_EN.
module dataio_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] index,
    input  logic [7:0] data,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       busy,
    output logic       done,
    output logic       SPI_SCK,
    output logic       SPI_SS2,
    output logic       SPI_DI,
    output logic [2:0] state_dbg
`ifdef DATAIO_CKSUM_EN
    ,
    output logic [7:0] cksum
`endif
);

    // Handshake: data_ready is asserted combinationally while the FSM waits for a
    // payload byte and data_valid is high; the byte transfers at the clock edge
    // that ends a cycle in which both are high. No other cycle transfers data.

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_SHIFT = 3'd2,
        S_NEXT  = 3'd3,
        S_DESEL = 3'd4,
        S_GAP   = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [1:0]       frame;
    logic             first_byte;
    logic             last_seen;
    logic [7:0]       shreg;
    logic [7:0]       idx_reg;

    logic             half_end;
    logic             cell_end;
    logic             gap_end;
    logic             byte_end;
    logic             more_bytes;
    logic             load_next;
    logic             start_ok;
    logic             sck_nx;
    logic             ss2_nx;
    logic             di_nx;

    // First byte of each frame is the command code.
    function automatic logic [7:0] cmd_byte(input logic [1:0] f);
        case (f)
            2'd0:    cmd_byte = 8'h55;
            2'd2:    cmd_byte = 8'h54;
            default: cmd_byte = 8'h53;
        endcase
    endfunction

    // Second byte of the non-payload frames.
    function automatic logic [7:0] arg_byte(input logic [1:0] f, input logic [7:0] idx);
        case (f)
            2'd0:    arg_byte = idx;
            2'd1:    arg_byte = 8'hFF;
            default: arg_byte = 8'h00;
        endcase
    endfunction

    assign half_end   = (cnt == CNT_W'(CLK_DIV - 1));
    assign cell_end   = (cnt == CNT_W'(2 * CLK_DIV - 1));
    assign gap_end    = (cnt == CNT_W'(GAP - 1));
    assign byte_end   = cell_end && (bit_cnt == 3'd7);
    assign more_bytes = first_byte || ((frame == 2'd2) && !last_seen);
    assign load_next  = (state == S_NEXT) && ((frame != 2'd2) || data_valid);
    assign start_ok   = start && ((state == S_IDLE) || (state == S_FIN));
    assign state_dbg  = state;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_FIN: state_nx = start_ok ? S_SEL : S_IDLE;
            S_SEL:         if (half_end) state_nx = S_SHIFT;
            S_SHIFT:       if (byte_end) state_nx = more_bytes ? S_NEXT : S_DESEL;
            S_NEXT:        if (load_next) state_nx = S_SHIFT;
            S_DESEL:       if (half_end) state_nx = S_GAP;
            S_GAP:         if (gap_end) state_nx = (frame == 2'd3) ? S_FIN : S_SEL;
            default:       state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b1;
        done       = 1'b0;
        data_ready = 1'b0;
        ss2_nx     = 1'b0;
        sck_nx     = 1'b0;
        di_nx      = 1'b0;
        case (state)
            S_IDLE: begin
                busy   = 1'b0;
                ss2_nx = 1'b1;
            end
            S_FIN: begin
                busy   = 1'b0;
                done   = 1'b1;
                ss2_nx = 1'b1;
            end
            S_GAP:   ss2_nx = 1'b1;
            S_SHIFT: begin
                sck_nx = (cnt >= CNT_W'(CLK_DIV));
                di_nx  = shreg[7];
            end
            S_NEXT:  data_ready = (frame == 2'd2) && data_valid && !reset;
            default: ;
        endcase
    end

    // Counters, shifter and frame bookkeeping.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            first_byte <= 1'b0;
            last_seen  <= 1'b0;
            shreg      <= '0;
            idx_reg    <= '0;
        end else begin
            case (state)
                S_IDLE, S_FIN: begin
                    cnt <= '0;
                    if (start_ok) begin
                        idx_reg    <= index;
                        frame      <= 2'd0;
                        first_byte <= 1'b1;
                        last_seen  <= 1'b0;
                        bit_cnt    <= 3'd0;
                        shreg      <= cmd_byte(2'd0);
                    end
                end
                S_SEL, S_DESEL: cnt <= half_end ? '0 : cnt + 1'b1;
                S_SHIFT: begin
                    if (cell_end) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= {shreg[6:0], 1'b0};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (load_next) begin
                        first_byte <= 1'b0;
                        if (frame == 2'd2) begin
                            shreg     <= data;
                            last_seen <= data_last;
                        end else begin
                            shreg <= arg_byte(frame, idx_reg);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        cnt        <= '0;
                        frame      <= frame + 2'd1;
                        first_byte <= 1'b1;
                        last_seen  <= 1'b0;
                        shreg      <= cmd_byte(frame + 2'd1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // SPI pins are registered so the wire never sees decode glitches.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            SPI_SCK <= 1'b0;
            SPI_SS2 <= 1'b1;
            SPI_DI  <= 1'b0;
        end else begin
            SPI_SCK <= sck_nx;
            SPI_SS2 <= ss2_nx;
            SPI_DI  <= di_nx;
        end
    end

`ifdef DATAIO_CKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset || start_ok) begin
            cksum <= 8'h00;
        end else if (data_ready) begin
            cksum <= cksum ^ data;
        end
    end
`endif

endmodule

// File: tb/tb_dataio_spi_master.sv
// Bench for dataio_spi_master: an SPI slave monitor decodes the wire into
// frames, and each download is compared with the byte sequence the protocol defines.
module tb_dataio_spi_master;

    localparam int CD = 2;
    localparam int GP = 4;

    logic       clk_sys    = 1'b0;
    logic       reset      = 1'b1;
    logic       start      = 1'b0;
    logic [7:0] index      = 8'h00;
    logic [7:0] data       = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_last  = 1'b0;
    logic       data_ready;
    logic       busy;
    logic       done;
    logic       SPI_SCK;
    logic       SPI_SS2;
    logic       SPI_DI;
    logic [2:0] state_dbg;
`ifdef DATAIO_CKSUM_EN
    logic [7:0] cksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] pay_q[$];

    // Slave-side observations
    logic [7:0] obs_bytes[$];
    int         obs_flen[$];
    logic [7:0] msh        = 8'h00;
    int         mbits      = 0;
    int         flen       = 0;
    int         cyc        = 0;
    int         ss2_fall_c = 0;
    int         ss2_rise_c = -1000;
    int         sck_fall_c = 0;
    int         sck_hi     = 0;
    int         timing_err = 0;
    bit         first_rise = 1'b0;
    logic       prev_sck   = 1'b0;
    logic       prev_ss2   = 1'b1;

    dataio_spi_master #(.CLK_DIV(CD), .GAP(GP)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .start      (start),
        .index      (index),
        .data       (data),
        .data_valid (data_valid),
        .data_last  (data_last),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done),
        .SPI_SCK    (SPI_SCK),
        .SPI_SS2    (SPI_SS2),
        .SPI_DI     (SPI_DI),
        .state_dbg  (state_dbg)
`ifdef DATAIO_CKSUM_EN
        ,
        .cksum      (cksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        cyc++;
        if (!SPI_SS2 && prev_ss2) begin
            if (obs_flen.size() > 0 && (cyc - ss2_rise_c) < GP) timing_err++;
            ss2_fall_c = cyc;
            first_rise = 1'b1;
            mbits      = 0;
            flen       = 0;
        end
        if (SPI_SS2 && !prev_ss2) begin
            if (!reset && (cyc - sck_fall_c) != CD) timing_err++;
            obs_flen.push_back(flen);
            ss2_rise_c = cyc;
        end
        if (SPI_SCK && !prev_sck) begin
            if (SPI_SS2) timing_err++;
            if (first_rise && (cyc - ss2_fall_c) != 2 * CD) timing_err++;
            first_rise = 1'b0;
            msh = {msh[6:0], SPI_DI};
            mbits++;
            if (mbits == 8) begin
                obs_bytes.push_back(msh);
                flen++;
                mbits = 0;
            end
            sck_hi = 1;
        end else if (SPI_SCK) begin
            sck_hi++;
        end
        if (!SPI_SCK && prev_sck) begin
            if (!reset && sck_hi != CD) timing_err++;
            sck_fall_c = cyc;
        end
        prev_sck = SPI_SCK;
        prev_ss2 = SPI_SS2;
    end

    // One complete download of pay_q; stall_at < 0 disables the stall window.
    task automatic run_download(input logic [7:0] idx, input int stall_at, input int stall_len,
                                input bit poke_start, input string tag);
        logic [7:0] exp_q[$];
        int         exp_len[$];
        int         n;
        int         pos      = 0;
        int         stall    = 0;
        int         cyc_i    = 0;
        int         bad      = 0;
        int         stall_bad = 0;
        int         late_done = 0;
        bit         seen_done = 1'b0;
        bit         stalling;
        logic [7:0] ck_exp   = 8'h00;

        n = pay_q.size();
        exp_q = '{8'h55, idx, 8'h53, 8'hFF, 8'h54};
        foreach (pay_q[i]) begin
            exp_q.push_back(pay_q[i]);
            ck_exp = ck_exp ^ pay_q[i];
        end
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h00);
        exp_len = '{2, 2, n + 1, 2};

        @(negedge clk_sys);
        #1;
        obs_bytes.delete();
        obs_flen.delete();
        timing_err = 0;
        start = 1'b1;
        index = idx;
        @(negedge clk_sys);
        start = 1'b0;
        index = 8'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_rise got %b exp 1", tag, busy);
        end
`ifdef DATAIO_CKSUM_EN
        checks++;
        if (cksum !== 8'h00) begin
            errors++;
            $display("FAIL %s cksum_clear got %h exp 00", tag, cksum);
        end
`endif

        while (!seen_done && cyc_i < 20000) begin
            stalling = (pos == stall_at) && (stall < stall_len);
            if (stalling) begin
                stall++;
                data_valid = 1'b0;
                if (stall > 60 && (SPI_SS2 !== 1'b0 || SPI_SCK !== 1'b0)) stall_bad++;
            end else if (pos < n) begin
                data_valid = ($urandom_range(0, 3) != 0);
                data       = pay_q[pos];
                data_last  = (pos == n - 1);
            end else begin
                data_valid = 1'($urandom);
                data       = 8'($urandom);
                data_last  = 1'($urandom);
            end
            start = poke_start && (cyc_i == 40);
            index = idx ^ 8'hFF;
            #1;
            if (data_ready === 1'b1) begin
                if (stalling || pos >= n || data_valid !== 1'b1) bad++;
                else pos++;
            end
            @(negedge clk_sys);
            cyc_i++;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_at_done got %b exp 0", tag, busy);
                end
`ifdef DATAIO_CKSUM_EN
                checks++;
                if (cksum !== ck_exp) begin
                    errors++;
                    $display("FAIL %s cksum got %h exp %h", tag, cksum, ck_exp);
                end
`endif
            end
        end
        start      = 1'b0;
        data_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            if (done !== 1'b0 || busy !== 1'b0) late_done++;
        end

        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s done_timeout got 0 exp 1", tag);
        end
        checks++;
        if (late_done != 0) begin
            errors++;
            $display("FAIL %s done_once got %0d extra exp 0", tag, late_done);
        end
        checks++;
        if (pos != n || bad != 0) begin
            errors++;
            $display("FAIL %s ready_count got %0d bad %0d exp %0d", tag, pos, bad, n);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL %s stall_idle got %0d exp 0", tag, stall_bad);
        end
        checks++;
        if (timing_err != 0) begin
            errors++;
            $display("FAIL %s wire_timing got %0d exp 0", tag, timing_err);
        end
        checks++;
        if (obs_flen.size() != 4) begin
            errors++;
            $display("FAIL %s frame_count got %0d exp 4", tag, obs_flen.size());
        end else begin
            for (int f = 0; f < 4; f++) begin
                if (obs_flen[f] != exp_len[f]) begin
                    errors++;
                    $display("FAIL %s frame%0d_len got %0d exp %0d", tag, f, obs_flen[f], exp_len[f]);
                end
            end
        end
        checks++;
        if (obs_bytes.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s byte_count got %0d exp %0d", tag, obs_bytes.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                if (obs_bytes[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s byte%0d got %h exp %h", tag, i, obs_bytes[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        data_valid = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if (SPI_SS2 !== 1'b1 || SPI_SCK !== 1'b0 || SPI_DI !== 1'b0) begin
            errors++;
            $display("FAIL reset_pins got ss2=%b sck=%b di=%b exp 1 0 0", SPI_SS2, SPI_SCK, SPI_DI);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got busy=%b done=%b ready=%b exp 0 0 0", busy, done, data_ready);
        end
`ifdef DATAIO_CKSUM_EN
        checks++;
        if (cksum !== 8'h00) begin
            errors++;
            $display("FAIL reset_cksum got %h exp 00", cksum);
        end
`endif
        #1;
        reset      = 1'b0;
        data_valid = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (data_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore got ready=%b busy=%b exp 0 0", data_ready, busy);
        end
    endtask

    task automatic test_full_download();
        pay_q = '{8'hA5, 8'h3C, 8'h81};
        run_download(8'h02, -1, 0, 1'b0, "full");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 10);
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            run_download(8'($urandom), -1, 0, 1'b0, "random");
        end
    endtask

    task automatic test_stall();
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_download(8'h05, 1, 100, 1'b0, "stall");
    endtask

    task automatic test_start_while_busy();
        pay_q = '{8'hDE, 8'hAD};
        run_download(8'h09, -1, 0, 1'b1, "start_busy");
    endtask

    task automatic test_reset_mid_byte();
        int guard = 0;
        bit hit   = 1'b0;
        @(negedge clk_sys);
        #1;
        obs_bytes.delete();
        obs_flen.delete();
        start = 1'b1;
        index = 8'h07;
        @(negedge clk_sys);
        start      = 1'b0;
        data       = 8'hA5;
        data_last  = 1'b0;
        data_valid = 1'b1;
        while (!hit && guard < 3000) begin
            @(negedge clk_sys);
            #1;
            guard++;
            if (obs_flen.size() == 2 && obs_bytes.size() == 5 && mbits == 4) hit = 1'b1;
        end
        checks++;
        if (!hit || msh[3:0] !== 4'hA) begin
            errors++;
            $display("FAIL mid_reach got hit=%b nibble=%h exp 1 a", hit, msh[3:0]);
        end
        reset      = 1'b1;
        data_valid = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (SPI_SS2 !== 1'b1 || SPI_SCK !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got ss2=%b sck=%b busy=%b exp 1 0 0", SPI_SS2, SPI_SCK, busy);
        end
        #1;
        reset = 1'b0;
        repeat (GP + 2) @(negedge clk_sys);
        pay_q = '{8'hA5, 8'h5A, 8'hC3};
        run_download(8'h07, -1, 0, 1'b0, "after_reset");
    endtask

`ifdef DATAIO_CKSUM_EN
    task automatic test_cksum();
        pay_q = '{8'h01, 8'h02, 8'h04};
        run_download(8'h03, -1, 0, 1'b0, "cksum");
        pay_q = '{8'h10};
        run_download(8'h04, -1, 0, 1'b0, "cksum_restart");
    endtask
`endif

    initial begin
        test_reset();
        test_full_download();
        test_random();
        test_stall();
        test_start_while_busy();
        test_reset_mid_byte();
`ifdef DATAIO_CKSUM_EN
        test_cksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
